pio_bank: RTL and testbench
===========================

Name: pio_bank

Overview:
- Parametrised, generalised successor to the fixed 32-bit single-channel PIO ports (hex, LEDs, display, buttons, input) on the PCIe BAR.
- One Avalon-MM slave exposes N_OUT output channels and N_IN input channels.
- Inputs get synchronisers, edge capture and a maskable interrupt.
- Sits behind the PCIe hard IP interconnect; replaces per-peripheral PIO instances with one configurable bank.

Parameters:
DATA_W, 32, width of every channel and of the Avalon data bus (multiple of 8)
N_OUT, 4, number of output channels (1..16)
N_IN, 2, number of input channels (1..16)
OUT_RESET, 0, reset value loaded into every output register (DATA_W bits)
EDGE_MODE, 0, capture edge type: 0 rising, 1 falling, 2 any
DEBOUNCE_CYC, 50000, stable-cycle count for debounce (used only with PIO_DEBOUNCE_EN)
ADDR_W, 6, word-address width; must satisfy 2**ADDR_W >= N_OUT + 4*N_IN

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
avs_address  in  ADDR_W  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  DATA_W  write data
avs_byteenable  in  DATA_W/8  write byte lanes
avs_readdata  out  DATA_W  registered read data
avs_readdatavalid  out  1  read data valid
irq  out  1  level interrupt
out_export  out  N_OUT*DATA_W  output channels, channel k at bits [k*DATA_W +: DATA_W]
in_export  in  N_IN*DATA_W  asynchronous input channels, same packing

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - out regs = OUT_RESET
  - mask, capture = 0
  - avs_readdata = 0, avs_readdatavalid = 0, irq = 0
  - sync flops = 0
- Register map (word addresses):
  - 0..N_OUT-1: output reg k, RW.
  - Input channel i has base B = N_OUT + 4*i:
    - B+0: data, RO (synchronised or debounced value)
    - B+1: irq mask, RW
    - B+2: edge capture, write-1-to-clear
    - B+3: reads 0
  - Unmapped addresses read 0. Writes to RO or unmapped addresses are ignored.
- Writes:
  - Take effect on the cycle after avs_write.
  - Only enabled byte lanes update.
  - No waitrequest; a write is accepted every cycle.
- Reads:
  - Fixed latency 1: avs_readdatavalid pulses the cycle after avs_read, with avs_readdata registered.
  - avs_readdata holds its value otherwise.
  - If read and write assert together on the same address, the read returns the pre-write value.
- Inputs:
  - Each input passes through a 2-flop synchroniser, then an edge detector against a previous-value flop.
  - Edge detection is gated off for the first 3 cycles after reset deasserts, so no false edge from reset values.
- Capture:
  - capture[b] sets on a qualifying edge of bit b.
  - W1C clears it.
  - If an edge and a W1C on the same bit occur in the same cycle, the edge wins and the bit stays 1.
- irq = registered OR over all channels of (capture & mask). It is asserted the cycle after the capture or mask update.
- Latency from an in_export change to data-register visibility is 2 cycles, plus 1 cycle for capture.
- Reset mid-transaction: a pending readdatavalid is dropped and all state returns to reset values.

Optional Feature:
- Macro: PIO_DEBOUNCE_EN.
- Defined:
  - Each input channel has a counter of width clog2(DEBOUNCE_CYC+1).
  - The counter resets to 0 whenever the synced word differs from the last sample, otherwise saturates at DEBOUNCE_CYC.
  - The debounced value updates when the counter reaches DEBOUNCE_CYC.
  - Edge detection and the data register use the debounced value.
  - Added latency: DEBOUNCE_CYC cycles.
- Undefined: the synced value feeds the edge detector directly, and no counter exists.

Decomposition:
- pio_bank_pkg: register offset constants (OFS_DATA=0, OFS_MASK=1, OFS_CAP=2, IN_STRIDE=4), edge-mode enum (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- Sub-module pio_in_channel: synchroniser, optional debounce, edge detect, capture, mask, and per-channel irq term. Instantiated N_IN times via generate.
- The top level holds the output regs, address decode and read mux.

Test Plan:
- Reset with OUT_RESET=32'hA5A5_0000, then read addr 0 -> readdata=32'hA5A5_0000 with readdatavalid one cycle after read; irq=0.
- Write addr 1 data 32'h1234_5678 be=4'b0011 over prior 32'hFFFF_FFFF -> out_export channel 1 = 32'hFFFF_5678 next cycle; readback matches.
- EDGE_MODE=0: set mask of channel 0 (addr N_OUT+1) = 32'h1, then drive in_export[0] 0->1 -> capture reads 32'h1 and irq=1 within 4 cycles; write 32'h1 to addr N_OUT+2 -> capture 0, irq 0.
- Same-cycle W1C and new rising edge on bit 0 -> capture bit 0 remains 1, irq stays high.
- Hold in_export=32'hFFFF_FFFF through reset and release -> no capture bits set, irq=0 after 10 cycles.
- With PIO_DEBOUNCE_EN and DEBOUNCE_CYC=8: glitch lasting 5 cycles -> data unchanged, no capture; a level held for 12 cycles -> data updates after 8 stable cycles and capture sets.

Source files
------------

// File: rtl/pio_bank_pkg.sv
// pio_bank_pkg: register offsets within an input-channel window and the
// edge-mode encoding shared by the PIO bank and its input channels.
package pio_bank_pkg;

  localparam int OFS_DATA  = 0;
  localparam int OFS_MASK  = 1;
  localparam int OFS_CAP   = 2;
  localparam int IN_STRIDE = 4;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

endpackage

// File: rtl/pio_in_channel.sv
// pio_in_channel: one input channel of the PIO bank. Synchronises the async
// input word, optionally debounces it (PIO_DEBOUNCE_EN), detects edges,
// holds the sticky capture and irq mask, and produces this channel's irq term.
module pio_in_channel #(
  parameter int DATA_W       = 32,
  parameter int EDGE_MODE    = 0,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_async,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  input  logic              mask_we,
  input  logic              cap_we,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] mask,
  output logic [DATA_W-1:0] capture,
  output logic              irq_term
);
  import pio_bank_pkg::*;

`ifdef PIO_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic [DATA_W-1:0] sync1, sync2, lvl, prev, edge_vec;
  logic [1:0]        arm_cnt;
  logic              armed;

  // Two-flop synchroniser for the asynchronous input word.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_async;
      sync2 <= sync1;
    end
  end

  if (DB_EN && DEBOUNCE_CYC > 0) begin : g_db
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);
    logic [DATA_W-1:0] samp, deb;
    logic [CNT_W-1:0]  cnt;

    // Stability counter: restarts on any change, debounced word follows once stable.
    always_ff @(posedge clk) begin
      if (reset) begin
        samp <= '0;
        deb  <= '0;
        cnt  <= '0;
      end else begin
        samp <= sync2;
        if (sync2 != samp)
          cnt <= '0;
        else if (cnt != CNT_MAX)
          cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_MAX)
          deb <= samp;
      end
    end
    assign lvl = deb;
  end else begin : g_nodb
    assign lvl = sync2;
  end

  assign armed = (arm_cnt == 2'd3);

  // Hold off edge detection for three cycles so reset values never look like an edge.
  always_ff @(posedge clk) begin
    if (reset)
      arm_cnt <= '0;
    else if (!armed)
      arm_cnt <= arm_cnt + 2'd1;
  end

  // Qualifying edges for the configured edge mode.
  always_comb begin
    if (EDGE_MODE == int'(EDGE_FALL))
      edge_vec = prev & ~lvl;
    else if (EDGE_MODE == int'(EDGE_ANY))
      edge_vec = prev ^ lvl;
    else
      edge_vec = lvl & ~prev;
    if (!armed)
      edge_vec = '0;
  end

  // Previous-value flop, byte-lane mask writes and sticky capture (edge beats W1C).
  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= '0;
      mask    <= '0;
      capture <= '0;
    end else begin
      prev <= lvl;
      if (mask_we)
        mask <= (mask & ~wmask) | (wdata & wmask);
      capture <= (cap_we ? (capture & ~(wdata & wmask)) : capture) | edge_vec;
    end
  end

  assign data     = lvl;
  assign irq_term = |(capture & mask);

endmodule

// File: rtl/pio_bank.sv
// pio_bank: Avalon-MM PIO bank with N_OUT output registers and N_IN input
// channels (synchroniser, edge capture, maskable level irq). Optional input
// debounce is enabled by defining PIO_DEBOUNCE_EN.
module pio_bank #(
  parameter int                DATA_W       = 32,
  parameter int                N_OUT        = 4,
  parameter int                N_IN         = 2,
  parameter logic [DATA_W-1:0] OUT_RESET    = '0,
  parameter int                EDGE_MODE    = 0,
  parameter int                DEBOUNCE_CYC = 50000,
  parameter int                ADDR_W       = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [DATA_W-1:0]       avs_writedata,
  input  logic [DATA_W/8-1:0]     avs_byteenable,
  output logic [DATA_W-1:0]       avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    irq,
  output logic [N_OUT*DATA_W-1:0] out_export,
  input  logic [N_IN*DATA_W-1:0]  in_export
);
  import pio_bank_pkg::*;

  logic [DATA_W-1:0] out_q   [N_OUT];
  logic [DATA_W-1:0] in_data [N_IN];
  logic [DATA_W-1:0] in_mask [N_IN];
  logic [DATA_W-1:0] in_cap  [N_IN];
  logic [DATA_W-1:0] wmask, rd_mux;
  logic [N_IN-1:0]   irq_terms, mask_we, cap_we;

  for (genvar b = 0; b < DATA_W/8; b++) begin : g_wmask
    assign wmask[b*8 +: 8] = {8{avs_byteenable[b]}};
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign out_export[k*DATA_W +: DATA_W] = out_q[k];
  end

  // Output registers with byte-lane writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= OUT_RESET;
    end else begin
      for (int k = 0; k < N_OUT; k++)
        if (avs_write && avs_address == ADDR_W'(k))
          out_q[k] <= (out_q[k] & ~wmask) | (avs_writedata & wmask);
    end
  end

  // Write decode for the per-channel mask and capture registers.
  always_comb begin
    mask_we = '0;
    cap_we  = '0;
    for (int i = 0; i < N_IN; i++) begin
      mask_we[i] = avs_write && (avs_address == ADDR_W'(N_OUT + IN_STRIDE*i + OFS_MASK));
      cap_we[i]  = avs_write && (avs_address == ADDR_W'(N_OUT + IN_STRIDE*i + OFS_CAP));
    end
  end

  // Read mux; unmapped and reserved offsets return zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_OUT; k++)
      if (avs_address == ADDR_W'(k)) rd_mux = out_q[k];
    for (int i = 0; i < N_IN; i++) begin
      if (avs_address == ADDR_W'(N_OUT + IN_STRIDE*i + OFS_DATA)) rd_mux = in_data[i];
      if (avs_address == ADDR_W'(N_OUT + IN_STRIDE*i + OFS_MASK)) rd_mux = in_mask[i];
      if (avs_address == ADDR_W'(N_OUT + IN_STRIDE*i + OFS_CAP))  rd_mux = in_cap[i];
    end
  end

  // Fixed one-cycle read latency; read data holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read)
        avs_readdata <= rd_mux;
    end
  end

  // Registered level interrupt over all channels.
  always_ff @(posedge clk) begin
    if (reset)
      irq <= 1'b0;
    else
      irq <= |irq_terms;
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    pio_in_channel #(
      .DATA_W       (DATA_W),
      .EDGE_MODE    (EDGE_MODE),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .in_async (in_export[i*DATA_W +: DATA_W]),
      .wdata    (avs_writedata),
      .wmask    (wmask),
      .mask_we  (mask_we[i]),
      .cap_we   (cap_we[i]),
      .data     (in_data[i]),
      .mask     (in_mask[i]),
      .capture  (in_cap[i]),
      .irq_term (irq_terms[i])
    );
  end

endmodule

// File: tb/tb_pio_bank.sv
// tb_pio_bank: directed-vector bench for pio_bank (4 outputs, 2 inputs,
// rising-edge capture). Debounce checks run only when PIO_DEBOUNCE_EN is set.
module tb_pio_bank;

  localparam int          DATA_W = 32;
  localparam int          N_OUT  = 4;
  localparam int          N_IN   = 2;
  localparam int          ADDR_W = 6;
  localparam int          DB_CYC = 8;
  localparam logic [31:0] OUT_RST = 32'hA5A5_0000;
`ifdef PIO_DEBOUNCE_EN
  localparam int X = DB_CYC + 2;
`else
  localparam int X = 0;
`endif

  logic                    clk, reset;
  logic [ADDR_W-1:0]       avs_address;
  logic                    avs_read, avs_write;
  logic [DATA_W-1:0]       avs_writedata;
  logic [DATA_W/8-1:0]     avs_byteenable;
  logic [DATA_W-1:0]       avs_readdata;
  logic                    avs_readdatavalid;
  logic                    irq;
  logic [N_OUT*DATA_W-1:0] out_export;
  logic [N_IN*DATA_W-1:0]  in_export;

  int n_vec = 0;
  int n_err = 0;

  pio_bank #(
    .DATA_W(DATA_W), .N_OUT(N_OUT), .N_IN(N_IN), .OUT_RESET(OUT_RST),
    .EDGE_MODE(0), .DEBOUNCE_CYC(DB_CYC), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .irq(irq),
    .out_export(out_export), .in_export(in_export)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    tick(1);
    avs_write      = 1'b0;
    avs_byteenable = '0;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
    avs_address = a;
    avs_read    = 1'b1;
    tick(1);
    avs_read    = 1'b0;
    check({tag, "_rdv"}, 128'(avs_readdatavalid), 128'(1'b1));
    check(tag, 128'(avs_readdata), 128'(exp));
  endtask

  initial begin
    reset = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0; in_export = '0;
    tick(3);
    reset = 1'b0;

    // reset state
    check("rst_rdv", 128'(avs_readdatavalid), 128'(1'b0));
    check("rst_irq", 128'(irq), 128'(1'b0));
    check("rst_out", out_export, {4{OUT_RST}});
    bus_read(0, OUT_RST, "rd_out0");
    tick(1);
    check("rdv_drop", 128'(avs_readdatavalid), 128'(1'b0));

    // byte-lane writes
    bus_write(1, 32'hFFFF_FFFF, 4'hF);
    bus_write(1, 32'h1234_5678, 4'b0011);
    check("out1_be", 128'(out_export[32 +: 32]), 128'(32'hFFFF_5678));
    bus_read(1, 32'hFFFF_5678, "rd_out1");
    bus_write(2, 32'hDEAD_BEEF, 4'b1000);
    check("out2_be", 128'(out_export[64 +: 32]), 128'(32'hDEA5_0000));

    // read and write together: read returns the pre-write value
    avs_address = 3; avs_writedata = 32'h1111_1111; avs_byteenable = 4'hF;
    avs_write = 1'b1; avs_read = 1'b1;
    tick(1);
    avs_write = 1'b0; avs_read = 1'b0; avs_byteenable = '0;
    check("rw_rdv", 128'(avs_readdatavalid), 128'(1'b1));
    check("rw_old", 128'(avs_readdata), 128'(OUT_RST));
    check("rw_out3", 128'(out_export[96 +: 32]), 128'(32'h1111_1111));

    // writes to RO / unmapped ignored, reserved and unmapped read zero
    bus_write(4, 32'hFFFF_FFFF, 4'hF);
    bus_read(4, 32'h0, "ro_data");
    bus_write(7, 32'hFFFF_FFFF, 4'hF);
    bus_read(7, 32'h0, "rsvd");
    bus_write(12, 32'hFFFF_FFFF, 4'hF);
    bus_read(12, 32'h0, "unmapped");

    // channel 1 edge with mask clear: capture sets, irq stays low
    in_export[36] = 1'b1;
    tick(4 + X);
    check("ch1_irq_masked", 128'(irq), 128'(1'b0));
    bus_read(10, 32'h0000_0010, "ch1_cap");
    bus_read(8, 32'h0000_0010, "ch1_data");
    bus_write(10, 32'h0000_0010, 4'hF);
    bus_read(10, 32'h0, "ch1_w1c");

    // channel 0 rising edge with mask set
    bus_write(5, 32'h1, 4'hF);
    bus_read(5, 32'h1, "ch0_mask");
    in_export[0] = 1'b1;
    tick(4 + X);
    check("ch0_irq_set", 128'(irq), 128'(1'b1));
    bus_read(6, 32'h1, "ch0_cap");
    bus_read(4, 32'h1, "ch0_data");
    bus_write(6, 32'h1, 4'hF);
    tick(1);
    check("ch0_irq_clr", 128'(irq), 128'(1'b0));
    bus_read(6, 32'h0, "ch0_cap_clr");

    // falling edge ignored in rising mode
    in_export[0] = 1'b0;
    tick(4 + X);
    bus_read(6, 32'h0, "ch0_fall");
    check("ch0_fall_irq", 128'(irq), 128'(1'b0));

    // W1C in the same cycle as a new rising edge: edge wins
    in_export[0] = 1'b1;
    tick(2 + X);
    bus_write(6, 32'h1, 4'hF);
    tick(1);
    check("race_irq", 128'(irq), 128'(1'b1));
    bus_read(6, 32'h1, "race_cap");

    // reset mid-read with inputs held high through reset
    avs_address = 0; avs_read = 1'b1; reset = 1'b1; in_export = '1;
    tick(1);
    avs_read = 1'b0;
    check("mid_rst_rdv", 128'(avs_readdatavalid), 128'(1'b0));
    check("mid_rst_rdata", 128'(avs_readdata), 128'(32'h0));
    check("mid_rst_irq", 128'(irq), 128'(1'b0));
    check("mid_rst_out3", 128'(out_export[96 +: 32]), 128'(OUT_RST));
    tick(2);
    reset = 1'b0;
    tick(10 + X);
    check("held_irq", 128'(irq), 128'(1'b0));
`ifndef PIO_DEBOUNCE_EN
    bus_read(6, 32'h0, "held_cap0");
    bus_read(10, 32'h0, "held_cap1");
`endif
    bus_read(4, 32'hFFFF_FFFF, "held_data0");
    bus_read(5, 32'h0, "held_mask0");

`ifdef PIO_DEBOUNCE_EN
    bus_write(6, 32'hFFFF_FFFF, 4'hF);
    in_export[31:0] = '0;
    tick(5);
    in_export[31:0] = '1;
    tick(20);
    bus_read(4, 32'hFFFF_FFFF, "db_glitch_data");
    bus_read(6, 32'h0, "db_glitch_cap");
    in_export[31:0] = '0;
    tick(20);
    bus_read(4, 32'h0, "db_low_data");
    in_export[31:0] = '1;
    tick(14);
    bus_read(4, 32'hFFFF_FFFF, "db_high_data");
    bus_read(6, 32'hFFFF_FFFF, "db_high_cap");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
